// File: rtl/ram_dump_tx.sv
// ram_dump_tx
// Reads back the 16-byte SAP-1 program RAM through the front-panel address and
// streams it out as ASCII hex text over an 8N1 UART. Each address produces one
// 6-character line: "<A>:<HH>\r\n". The lines run from address 0 to F in order.
//
// Ports
//   sysclk    system clock
//   reset_n   asynchronous active-low reset
//   start     single-cycle pulse; begins a dump when idle
//   mem_adr   RAM address being read (front-panel address)
//   mem_data  RAM read data (W bus in program mode)
//   tx        UART serial output, idles high
//   busy      high from accepting start until done
//   done      single-cycle pulse when the dump completes
//
// Top FSM
//   state   | meaning
//   T_IDLE  | waiting for start
//   T_SETADR| mem_adr just driven, load latency counter
//   T_WAIT  | let RAM read data settle for MEM_LAT cycles
//   T_LATCH | capture mem_data into data_byte
//   T_SEND  | hand the six line characters to the UART one at a time
//   T_NEXT  | advance address or finish
//   T_DONE  | done pulse, busy dropped
//
// UART FSM
//   state   | meaning
//   U_IDLE  | line high, waiting for a character
//   U_START | start bit (low)
//   U_DATA  | 8 data bits, LSB first
//   U_STOP  | stop bit (high)
module ram_dump_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MEM_LAT      = 2
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       start,
    output logic [3:0] mem_adr,
    input  logic [7:0] mem_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        T_IDLE, T_SETADR, T_WAIT, T_LATCH, T_SEND, T_NEXT, T_DONE
    } top_state_t;

    typedef enum logic [1:0] {
        U_IDLE, U_START, U_DATA, U_STOP
    } uart_state_t;

    top_state_t        top_state_q, top_state_d;
    uart_state_t       uart_state_q, uart_state_d;
    logic [3:0]        mem_adr_q, mem_adr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LAT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]        data_byte_q, data_byte_d;
    logic [2:0]        char_idx_q, char_idx_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_char_q, tx_char_d;
    logic [7:0]        shift_q, shift_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic              tx_q, tx_d;
    logic [7:0]        char_sel;
    logic              uart_free;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    assign mem_adr = mem_adr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign tx      = tx_q;

    always_comb begin
        top_state_d  = top_state_q;
        uart_state_d = uart_state_q;
        mem_adr_d    = mem_adr_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        wait_cnt_d   = wait_cnt_q;
        data_byte_d  = data_byte_q;
        char_idx_d   = char_idx_q;
        tx_valid_d   = 1'b0;
        tx_char_d    = tx_char_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        baud_cnt_d   = baud_cnt_q;
        tx_d         = tx_q;

        case (char_idx_q)
            3'd0:    char_sel = hex_ascii(mem_adr_q);
            3'd1:    char_sel = 8'h3A;
            3'd2:    char_sel = hex_ascii(data_byte_q[7:4]);
            3'd3:    char_sel = hex_ascii(data_byte_q[3:0]);
            3'd4:    char_sel = 8'h0D;
            default: char_sel = 8'h0A;
        endcase

        // A character handed over last cycle is still in flight to the UART
        // until it leaves U_IDLE, so the pending strobe also blocks issuing.
        uart_free = (uart_state_q == U_IDLE) && !tx_valid_q;

        case (top_state_q)
            T_IDLE: begin
                if (start) begin
                    mem_adr_d   = 4'h0;
                    busy_d      = 1'b1;
                    top_state_d = T_SETADR;
                end
            end
            T_SETADR: begin
                wait_cnt_d  = LAT_LOAD;
                top_state_d = T_WAIT;
            end
            T_WAIT: begin
                if (wait_cnt_q == '0) begin
                    top_state_d = T_LATCH;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            T_LATCH: begin
                data_byte_d = mem_data;
                char_idx_d  = 3'd0;
                top_state_d = T_SEND;
            end
            T_SEND: begin
                if (uart_free) begin
                    if (char_idx_q == 3'd6) begin
                        top_state_d = T_NEXT;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_char_d  = char_sel;
                        char_idx_d = char_idx_q + 3'd1;
                    end
                end
            end
            T_NEXT: begin
                if (mem_adr_q == 4'hF) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    top_state_d = T_DONE;
                end else begin
                    mem_adr_d   = mem_adr_q + 4'd1;
                    top_state_d = T_SETADR;
                end
            end
            T_DONE: begin
                top_state_d = T_IDLE;
            end
            default: begin
                top_state_d = T_IDLE;
            end
        endcase

        case (uart_state_q)
            U_IDLE: begin
                if (tx_valid_q) begin
                    shift_d      = tx_char_q;
                    tx_d         = 1'b0;
                    baud_cnt_d   = BAUD_LOAD;
                    uart_state_d = U_START;
                end
            end
            U_START: begin
                if (baud_cnt_q == '0) begin
                    tx_d         = shift_q[0];
                    bit_cnt_d    = 4'd0;
                    baud_cnt_d   = BAUD_LOAD;
                    uart_state_d = U_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            U_DATA: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = BAUD_LOAD;
                    if (bit_cnt_q == 4'd7) begin
                        tx_d         = 1'b1;
                        uart_state_d = U_STOP;
                    end else begin
                        tx_d      = shift_q[1];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            U_STOP: begin
                if (baud_cnt_q == '0) begin
                    uart_state_d = U_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: begin
                tx_d         = 1'b1;
                uart_state_d = U_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            top_state_q  <= T_IDLE;
            uart_state_q <= U_IDLE;
            mem_adr_q    <= 4'h0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wait_cnt_q   <= '0;
            data_byte_q  <= 8'h00;
            char_idx_q   <= 3'd0;
            tx_valid_q   <= 1'b0;
            tx_char_q    <= 8'h00;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 4'd0;
            baud_cnt_q   <= '0;
            tx_q         <= 1'b1;
        end else begin
            top_state_q  <= top_state_d;
            uart_state_q <= uart_state_d;
            mem_adr_q    <= mem_adr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wait_cnt_q   <= wait_cnt_d;
            data_byte_q  <= data_byte_d;
            char_idx_q   <= char_idx_d;
            tx_valid_q   <= tx_valid_d;
            tx_char_q    <= tx_char_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            baud_cnt_q   <= baud_cnt_d;
            tx_q         <= tx_d;
        end
    end

endmodule

// File: doc/ram_dump_tx.md
Name: ram_dump_tx

Overview:
- Reads back the 16-byte SAP-1 program RAM and streams it out as ASCII hex over a UART TX line (8N1).
- It is the read-out counterpart to the front-panel write path that loads RAM from the keypad.
- It sits beside the sap1 core in program mode. It drives the front-panel address, samples the RAM data, and transmits one text line per address.

Parameters:
- CLKS_PER_BIT, 868, sysclk cycles per UART bit (100 MHz / 115200).
- MEM_LAT, 2, sysclk cycles from a mem_adr change until mem_data is valid.

Ports:
- sysclk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a dump when idle.
- mem_adr  out  4  RAM address to read; connects to the front-panel address.
- mem_data  in  8  RAM read data; the W bus value in program mode.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high from accepting start until done.
- done  out  1  single-cycle pulse when the dump completes.

Behaviour:
- Reset (asynchronous, reset_n low): tx=1, busy=0, done=0, mem_adr=0. Both FSMs go to IDLE and all counters clear.
- Line format per address, 6 characters: hex address digit, ':', high data nibble, low data nibble, CR (0x0D), LF (0x0A).
- Hex digits are uppercase ASCII: 0-9 map to 0x30-0x39, A-F map to 0x41-0x46.
- A full dump is 16 lines, 96 characters, addresses 0 to F in order.
- Top FSM: IDLE -> SETADR -> WAIT -> LATCH -> SEND -> NEXT -> DONE.
  - IDLE: start=1 sets mem_adr=0 and busy=1, then goes to SETADR the next cycle.
  - WAIT: counts MEM_LAT cycles after mem_adr is driven.
  - LATCH: captures mem_data into an internal byte register. mem_data is ignored at all other times.
  - SEND: issues characters 0..5 to the UART sub-FSM one at a time. Each character is issued only when the UART is idle.
  - NEXT: if mem_adr=F, goes to DONE. Otherwise mem_adr increments and the FSM returns to SETADR.
  - DONE: done=1 for one cycle, busy=0 in that same cycle, then IDLE. mem_adr holds F until the next start.
- UART sub-FSM: IDLE, START, DATA, STOP.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - One frame takes exactly 10*CLKS_PER_BIT cycles. tx changes only on bit-period boundaries.
- Character spacing: the next character's start bit may begin no earlier than the cycle after the previous stop bit ends. Gap between characters within a line is at most 2 cycles.
- start while busy=1 is ignored and does not restart or queue a dump.
- start in the same cycle as the done pulse is ignored.
- A reset_n assertion mid-frame forces tx=1 asynchronously and abandons the dump. No partial recovery is attempted.
- A mem_data change after LATCH has no effect on the line being sent.
- The bit counter is 4 bits and the baud counter is wide enough for CLKS_PER_BIT-1. No output is combinational from inputs.

Test Plan (bench uses CLKS_PER_BIT=4, MEM_LAT=2, RAM model returning data=address*0x11 with data at address 0 = 0x3E):
- Reset: hold reset_n=0 mid-frame -> tx=1, busy=0, mem_adr=0 within the same cycle. They stay so after release with no start.
- Single line: pulse start, decode the first 6 frames -> 0x30,0x3A,0x33,0x45,0x0D,0x0A ("0:3E\r\n").
  - Each frame is 40 cycles: start bit low, LSB first, stop bit high.
- Full dump: decode 96 characters. Line for address A reads "A:AA\r\n", line for address F reads "F:FF\r\n".
  - done pulses once, exactly 1-3 cycles after the final LF stop bit ends. busy falls with done.
- Latch timing: change mem_data at the 3rd cycle after mem_adr changes -> the transmitted data is the value present in the LATCH cycle. Later changes are not transmitted.
- Ignored start: pulse start during address 5 and again coincident with done -> exactly 96 characters, no restart, busy stays low afterwards.
- Back-to-back: start again 1 cycle after done -> a second identical 96-character dump beginning at address 0.
